// File: rtl/md_seq_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// HI/LO write selects, latencies and the latched request payload.
package md_seq_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned DW      = 64;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned MUL_LAT = 5;
   localparam int unsigned DIV_LAT = 10;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_MADD  = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4
   } md_op_e;

   typedef enum logic [1:0] {
      MD_WE_NONE = 2'd0,
      MD_WE_HI   = 2'd1,
      MD_WE_LO   = 2'd2,
      MD_WE_RSVD = 2'd3
   } md_we_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_e;

   typedef struct packed {
      md_op_e          op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
   } md_req_t;

   // Unknown op codes collapse to MULT so latency and result stay consistent.
   function automatic md_op_e norm_op(input logic [2:0] op);
      md_op_e r;
      case (op)
         3'd1:    r = MD_MULTU;
         3'd2:    r = MD_MADD;
         3'd3:    r = MD_DIV;
         3'd4:    r = MD_DIVU;
         default: r = MD_MULT;
      endcase
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] lat_of(input md_op_e op);
      logic [CNT_W-1:0] r;
      case (op)
         MD_DIV, MD_DIVU: r = CNT_W'(DIV_LAT);
         default:         r = CNT_W'(MUL_LAT);
      endcase
      return r;
   endfunction

endpackage

// File: rtl/md_seq_arith.sv
// Combinational result path: products, multiply-accumulate and a single
// shared magnitude divider used for both signed and unsigned division.
module md_arith
   import md_seq_pkg::*;
(
   input  md_op_e          op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   output logic [DW-1:0]   result_c,
   output logic            div_zero_c
);

   logic signed [DW-1:0] sprod;
   logic [DW-1:0]        uprod;
   logic                 sgn;
   logic                 a_neg;
   logic                 b_neg;
   logic [XLEN-1:0]      a_mag;
   logic [XLEN-1:0]      b_mag;
   logic [XLEN-1:0]      d_mag;
   logic [XLEN-1:0]      q_mag;
   logic [XLEN-1:0]      r_mag;
   logic [XLEN-1:0]      quo;
   logic [XLEN-1:0]      rem;

   always_comb begin
      sprod = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{b[XLEN-1]}}, b});
      uprod = {XLEN'(0), a} * {XLEN'(0), b};
   end

   // Signed division runs on magnitudes; -2^31 / -1 wraps to 0x80000000 naturally.
   always_comb begin
      div_zero_c = (b == '0);
      sgn        = (op == MD_DIV);
      a_neg      = sgn & a[XLEN-1];
      b_neg      = sgn & b[XLEN-1];
      a_mag      = a_neg ? (~a + XLEN'(1)) : a;
      b_mag      = b_neg ? (~b + XLEN'(1)) : b;
      d_mag      = div_zero_c ? XLEN'(1) : b_mag;
      q_mag      = a_mag / d_mag;
      r_mag      = a_mag % d_mag;
      quo        = (a_neg ^ b_neg) ? (~q_mag + XLEN'(1)) : q_mag;
      rem        = a_neg ? (~r_mag + XLEN'(1)) : r_mag;
   end

   always_comb begin
      result_c = DW'(sprod);
      case (op)
         MD_MULTU:        result_c = uprod;
         MD_MADD:         result_c = {hi, lo} + DW'(sprod);
         MD_DIV, MD_DIVU: result_c = {rem, quo};
         default:         result_c = DW'(sprod);
      endcase
   end

endmodule

// File: rtl/md_seq.sv
// HI/LO multiply/divide sequencer: fixed-latency FSM, HI/LO registers,
// mthi/mtlo writes and the D-stage stall request.
module md_seq
   import md_seq_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      md_op,
   input  logic [XLEN-1:0] rs_val,
   input  logic [XLEN-1:0] rt_val,
   input  logic [1:0]      md_we,
   input  logic [XLEN-1:0] wdata,
   input  logic            md_use_d,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic            busy,
   output logic            stall
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   md_req_t          req_q, req_d;
   logic [XLEN-1:0]  hi_q, hi_d;
   logic [XLEN-1:0]  lo_q, lo_d;
   logic [DW-1:0]    result_c;
   logic             div_zero_c;
   md_op_e           op_n;

   md_arith u_arith (
      .op         (req_q.op),
      .a          (req_q.a),
      .b          (req_q.b),
      .hi         (hi_q),
      .lo         (lo_q),
      .result_c   (result_c),
      .div_zero_c (div_zero_c)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Next state, counter and HI/LO update; start outranks mthi/mtlo in IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      op_n    = norm_op(md_op);
      case (state_q)
         IDLE: begin
            if (start) begin
               req_d.op = op_n;
               req_d.a  = rs_val;
               req_d.b  = rt_val;
               cnt_d    = lat_of(op_n);
               state_d  = RUN;
            end else begin
               case (md_we_e'(md_we))
                  MD_WE_HI: hi_d = wdata;
                  MD_WE_LO: lo_d = wdata;
                  default:  ;
               endcase
            end
         end
         RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               state_d = IDLE;
               cnt_d   = '0;
               if (!(div_zero_c && (req_q.op == MD_DIV || req_q.op == MD_DIVU))) begin
                  hi_d = result_c[DW-1:XLEN];
                  lo_d = result_c[XLEN-1:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign hi    = hi_q;
   assign lo    = lo_q;
   assign busy  = (state_q == RUN);
   assign stall = reset & md_use_d & (busy | start);

endmodule

// File: tb/tb_md_seq.sv
// Directed bench for md_seq: a cycle model built from the arithmetic rules
// is compared every cycle, plus hand-computed results per scenario.
module tb_md_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [1:0]  md_we;
   logic [31:0] wdata;
   logic        md_use_d;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic        m_run = 1'b0;
   int          m_rem = 0;
   logic [2:0]  m_op = '0;
   logic [31:0] m_a = '0;
   logic [31:0] m_b = '0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   md_seq dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .md_op    (md_op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .md_we    (md_we),
      .wdata    (wdata),
      .md_use_d (md_use_d),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .stall    (stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // New {hi,lo} for a completed operation, using wide integer arithmetic.
   function automatic logic [63:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd1: res = {32'b0, a} * {32'b0, b};
         3'd2: res = {h, l} + 64'(sa * sb);
         3'd3: begin
            if (b == 32'd0) res = {h, l};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         3'd4: begin
            if (b == 32'd0) res = {h, l};
            else res = {a % b, a / b};
         end
         default: res = 64'(sa * sb);
      endcase
      return res;
   endfunction

   always @(posedge clk) begin
      if (!reset) begin
         m_run = 1'b0;
         m_rem = 0;
         m_hi  = '0;
         m_lo  = '0;
      end else if (m_run) begin
         m_rem--;
         if (m_rem == 0) begin
            m_run = 1'b0;
            {m_hi, m_lo} = model_res(m_op, m_a, m_b, m_hi, m_lo);
         end
      end else if (start) begin
         m_run = 1'b1;
         m_op  = md_op;
         m_a   = rs_val;
         m_b   = rt_val;
         m_rem = (md_op == 3'd3 || md_op == 3'd4) ? 10 : 5;
      end else if (md_we == 2'd1) begin
         m_hi = wdata;
      end else if (md_we == 2'd2) begin
         m_lo = wdata;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_hi", 64'(hi), 64'(m_hi));
         check("cyc_lo", 64'(lo), 64'(m_lo));
         check("cyc_busy", 64'(busy), 64'(m_run));
         check("cyc_stall", 64'(stall), 64'(reset & md_use_d & (m_run | start)));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mw(input logic [1:0] we, input logic [31:0] wd);
      md_we = we;
      wdata = wd;
      tick();
      md_we = 2'd0;
   endtask

   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] we, input logic [31:0] wd,
                         input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      start  = 1'b1;
      md_op  = op;
      rs_val = a;
      rt_val = b;
      md_we  = we;
      wdata  = wd;
      tick();
      start = 1'b0;
      md_we = 2'd0;
      n = 0;
      while (busy && n < 40) begin
         n++;
         tick();
      end
      check({name, "_lat"}, 64'(n), 64'(exp_lat));
      check({name, "_hi"}, 64'(hi), 64'(exp_hi));
      check({name, "_lo"}, 64'(lo), 64'(exp_lo));
   endtask

   initial begin
      int n;
      int i;
      reset    = 1'b0;
      start    = 1'b0;
      md_op    = '0;
      rs_val   = '0;
      rt_val   = '0;
      md_we    = '0;
      wdata    = '0;
      md_use_d = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      check("rst_hi", 64'(hi), 64'h0);
      check("rst_lo", 64'(lo), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      reset = 1'b1;
      tick();

      run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 2'd0, 32'd0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 2'd0, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      mw(2'd1, 32'd1);
      mw(2'd2, 32'd2);
      run_op("divu_z", 3'd4, 32'd7, 32'd0, 2'd0, 32'd0, 10, 32'd1, 32'd2);

      mw(2'd2, 32'h10);
      mw(2'd1, 32'h0);
      run_op("madd", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 32'd0, 5, 32'h0, 32'h11);

      // Stall window, with a stray start and mthi issued mid-operation.
      md_use_d = 1'b1;
      start    = 1'b1;
      md_op    = 3'd0;
      rs_val   = 32'h0001_0000;
      rt_val   = 32'h0001_0000;
      #1;
      check("stall_start", 64'(stall), 64'h1);
      tick();
      start = 1'b0;
      n = 0;
      i = 0;
      while (busy && i < 40) begin
         if (stall) n++;
         start  = (i == 1);
         md_op  = 3'd4;
         rs_val = 32'd9;
         rt_val = 32'd3;
         md_we  = (i == 2) ? 2'd1 : 2'd0;
         wdata  = 32'h0000_DEAD;
         tick();
         i++;
      end
      start = 1'b0;
      md_we = 2'd0;
      #1;
      check("stall_run", 64'(n), 64'd5);
      check("stall_lat", 64'(i), 64'd5);
      check("stall_after", 64'(stall), 64'h0);
      check("stall_hi", 64'(hi), 64'h1);
      check("stall_lo", 64'(lo), 64'h0);
      md_use_d = 1'b0;
      tick();

      // Reset in the 4th RUN cycle aborts the divide.
      start  = 1'b1;
      md_op  = 3'd3;
      rs_val = 32'd100;
      rt_val = 32'd7;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("abort_busy", 64'(busy), 64'h0);
      check("abort_hi", 64'(hi), 64'h0);
      check("abort_lo", 64'(lo), 64'h0);
      start  = 1'b1;
      md_op  = 3'd0;
      rs_val = 32'd3;
      rt_val = 32'd3;
      tick();
      start = 1'b0;
      reset = 1'b1;
      check("rst_start_busy", 64'(busy), 64'h0);
      tick();
      check("rst_start_busy2", 64'(busy), 64'h0);

      run_op("multu_we", 3'd1, 32'd2, 32'd3, 2'd2, 32'h55, 5, 32'h0, 32'h6);
      run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 2'd0, 32'd0, 10, 32'h0, 32'h8000_0000);
      run_op("op7", 3'd7, 32'hFFFF_FFFF, 32'd2, 2'd0, 32'd0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 32'd0, 5, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div_neg", 3'd3, 32'd7, 32'hFFFF_FFFE, 2'd0, 32'd0, 10, 32'h1, 32'hFFFF_FFFD);
      run_op("divu_big", 3'd4, 32'hFFFF_FFFF, 32'd10, 2'd0, 32'd0, 10, 32'h5, 32'h1999_9999);

      tick();
      tick();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_seq.md
MD_SEQ -- requirements
Module: md_seq

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-003 start  input  1  E-stage issue pulse for mult/multu/madd/div/divu.
REQ-004 md_op  input  3  operation code from shared package, sampled with start.
REQ-005 rs_val  input  32  operand A, sampled with start.
REQ-006 rt_val  input  32  operand B, sampled with start.
REQ-007 md_we  input  2  0=none, 1=write HI (mthi), 2=write LO (mtlo), 3=none.
REQ-008 wdata  input  32  data for mthi/mtlo.
REQ-009 md_use_d  input  1  D-stage instruction touches HI/LO (mult*, madd, div*, mfhi, mflo, mthi, mtlo).
REQ-010 hi  output  32  HI register, reset 0.
REQ-011 lo  output  32  LO register, reset 0.
REQ-012 busy  output  1  operation in progress, reset 0.
REQ-013 stall  output  1  combinational D-stage stall request, 0 during reset.

Function
REQ-014 The FSM SHALL have two states: IDLE and RUN; the reset state SHALL be IDLE.
REQ-015 IDLE + start=1 SHALL latch md_op, rs_val and rt_val, load the counter with the latency, and enter RUN.
REQ-016 Latency SHALL be 5 cycles for MULT, MULTU and MADD, and 10 cycles for DIV and DIVU.
REQ-017 busy SHALL be 1 in exactly the N cycles following the start cycle; the counter SHALL decrement once per RUN cycle.
REQ-018 At the edge ending the Nth RUN cycle, hi/lo SHALL update, busy SHALL fall, and the FSM SHALL return to IDLE.
REQ-019 Results SHALL be visible on hi/lo in the first cycle with busy=0.
REQ-020 MULT SHALL write {hi,lo} = signed 64-bit product.
REQ-021 MULTU SHALL write {hi,lo} = unsigned 64-bit product.
REQ-022 MADD SHALL write {hi,lo} = {hi,lo} + signed product, using the hi/lo values at completion, modulo 2^64.
REQ-023 DIV SHALL write lo = quotient truncated toward zero and hi = remainder carrying the sign of the dividend.
REQ-024 DIVU SHALL write lo/hi = unsigned quotient/remainder.
REQ-025 Divisor 0: the full latency SHALL elapse and hi/lo SHALL be left unchanged.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF SHALL produce lo=0x80000000, hi=0.
REQ-027 start while in RUN SHALL be ignored; the in-flight operation SHALL be unaffected.
REQ-028 md_we in IDLE with start=0 SHALL write wdata to the selected register at the next edge.
REQ-029 md_we SHALL be ignored in RUN and in a cycle where start=1 (start has priority).
REQ-030 stall SHALL equal md_use_d & (busy | start).
REQ-031 md_op codes outside the package set SHALL be treated as MULT.

Reset
REQ-032 With reset=0 at a rising edge: state=IDLE, counter=0, busy=0, hi=0, lo=0, latched operands=0.
REQ-033 Reset during RUN SHALL abort the operation and write no result.
REQ-034 start asserted in the same cycle as reset SHALL be ignored.

Structure
REQ-035 The shared package SHALL hold the md_op codes (MD_MULT=0, MD_MULTU=1, MD_MADD=2, MD_DIV=3, MD_DIVU=4), the md_we codes, and the latency constants MUL_LAT=5 and DIV_LAT=10.
REQ-036 A combinational sub-module md_arith SHALL compute the 64-bit result and a div-by-zero flag from the latched operands, op and current hi/lo.
REQ-037 md_seq SHALL own the FSM, the counter, the HI/LO registers and the stall logic.

Verification
REQ-038 MULT 0xFFFFFFFE x 3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-039 DIV -7 / 2 -> busy high for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 with prior hi=1, lo=2 -> hi=1, lo=2 after 10 cycles.
REQ-040 mtlo 0x10, mthi 0x0, then MADD 0xFFFFFFFF x 0xFFFFFFFF -> hi=0, lo=0x11.
REQ-041 md_use_d=1 held from the start cycle -> stall=1 in the start cycle and the 5 RUN cycles, 0 afterwards; start and md_we=1 during RUN are ignored and hi is unchanged.
REQ-042 DIV started, reset=0 in the 4th RUN cycle -> next cycle busy=0, hi=lo=0, state IDLE.
REQ-043 Simultaneous start (MULTU 2x3) and md_we=2 with wdata=0x55 -> lo=6 after 5 cycles; 0x55 is never written.
